// File: rtl/bit_sayici_if.sv
// bit_sayici_if: operand/result handshake bundle for the bit counting unit.
//   gecerli_i/hazir_o : operand valid / unit ready
//   islem_i           : 00 clz, 01 ctz, 10 cpop, 11 reserved
//   deger_i, etiket_i : operand and pass-through tag
//   gecerli_o/hazir_i : result valid / consumer ready
//   sonuc_o, etiket_o : zero-extended count and its tag
// The master modport is the issuing side; the slave modport is the unit.
interface bit_sayici_if #(
  parameter int unsigned VERI_BIT   = 32,
  parameter int unsigned ETIKET_BIT = 4
);
  localparam int unsigned SONUC_BIT = $clog2(VERI_BIT) + 1;

  logic                  gecerli_i;
  logic                  hazir_o;
  logic [1:0]            islem_i;
  logic [VERI_BIT-1:0]   deger_i;
  logic [ETIKET_BIT-1:0] etiket_i;
  logic                  gecerli_o;
  logic                  hazir_i;
  logic [SONUC_BIT-1:0]  sonuc_o;
  logic [ETIKET_BIT-1:0] etiket_o;

  modport master (
    output gecerli_i, islem_i, deger_i, etiket_i, hazir_i,
    input  hazir_o, gecerli_o, sonuc_o, etiket_o
  );

  modport slave (
    input  gecerli_i, islem_i, deger_i, etiket_i, hazir_i,
    output hazir_o, gecerli_o, sonuc_o, etiket_o
  );
endinterface

// File: rtl/bit_sayici.sv
// bit_sayici: two-stage pipelined clz / ctz / popcount unit.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset
//   temizle_i  : flush, drops both stages at the next edge
//   bus        : operand/result handshake (bit_sayici_if.slave)
// Stage A1 registers per-byte leading/trailing-zero counts, popcounts and
// all-zero flags; stage A2 combines them into the final count.
module bit_sayici #(
  parameter int unsigned VERI_BIT   = 32,
  parameter int unsigned ETIKET_BIT = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         temizle_i,
  bit_sayici_if.slave  bus
);
  localparam int unsigned SONUC_BIT = $clog2(VERI_BIT) + 1;
  localparam int unsigned BAYT      = VERI_BIT / 8;

  typedef enum logic [1:0] {
    ISLEM_CLZ  = 2'b00,
    ISLEM_CTZ  = 2'b01,
    ISLEM_CPOP = 2'b10,
    ISLEM_RSV  = 2'b11
  } islem_e;

  // Stage A1
  logic                      a1_v_q, a1_v_d;
  islem_e                    a1_islem_q, a1_islem_d;
  logic [ETIKET_BIT-1:0]     a1_etiket_q, a1_etiket_d;
  logic [BAYT-1:0][3:0]      a1_lz_q, a1_lz_d;
  logic [BAYT-1:0][3:0]      a1_tz_q, a1_tz_d;
  logic [BAYT-1:0][3:0]      a1_pc_q, a1_pc_d;
  logic [BAYT-1:0]           a1_sifir_q, a1_sifir_d;

  // Stage A2
  logic                      a2_v_q, a2_v_d;
  logic [SONUC_BIT-1:0]      a2_sonuc_q, a2_sonuc_d;
  logic [ETIKET_BIT-1:0]     a2_etiket_q, a2_etiket_d;

  logic a2_load;
  logic hazir;

  assign a2_load = ~a2_v_q | bus.hazir_i;
  assign hazir   = ~temizle_i & ~rst_i & (~a1_v_q | a2_load);

  assign bus.hazir_o   = hazir;
  assign bus.gecerli_o = a2_v_q;
  assign bus.sonuc_o   = a2_sonuc_q;
  assign bus.etiket_o  = a2_etiket_q;

  // A1 is free whenever hazir is high: either empty or advancing into A2.
  always_comb begin : a1_sonraki
    logic [7:0] bayt;
    logic       gordu;
    bayt        = '0;
    gordu       = 1'b0;
    a1_v_d      = a1_v_q;
    a1_islem_d  = a1_islem_q;
    a1_etiket_d = a1_etiket_q;
    a1_lz_d     = a1_lz_q;
    a1_tz_d     = a1_tz_q;
    a1_pc_d     = a1_pc_q;
    a1_sifir_d  = a1_sifir_q;
    if (temizle_i) begin
      a1_v_d = 1'b0;
    end else if (hazir) begin
      a1_v_d = bus.gecerli_i;
      if (bus.gecerli_i) begin
        a1_islem_d  = islem_e'(bus.islem_i);
        a1_etiket_d = bus.etiket_i;
        for (int unsigned b = 0; b < BAYT; b++) begin
          bayt       = bus.deger_i[8*b +: 8];
          a1_lz_d[b] = '0;
          a1_tz_d[b] = '0;
          a1_pc_d[b] = '0;
          gordu = 1'b0;
          for (int unsigned j = 0; j < 8; j++) begin
            if (!gordu && !bayt[7-j]) a1_lz_d[b] = a1_lz_d[b] + 4'd1;
            else                      gordu = 1'b1;
          end
          gordu = 1'b0;
          for (int unsigned j = 0; j < 8; j++) begin
            if (!gordu && !bayt[j]) a1_tz_d[b] = a1_tz_d[b] + 4'd1;
            else                    gordu = 1'b1;
          end
          for (int unsigned j = 0; j < 8; j++) begin
            a1_pc_d[b] = a1_pc_d[b] + {3'b000, bayt[j]};
          end
          a1_sifir_d[b] = (bayt == 8'h00);
        end
      end
    end
  end

  // Zero runs: keep adding per-byte counts until the first non-zero byte,
  // whose own count closes the sum.
  always_comb begin : a2_sonraki
    logic [SONUC_BIT-1:0] toplam;
    logic                 dur;
    toplam      = '0;
    dur         = 1'b0;
    a2_v_d      = a2_v_q;
    a2_sonuc_d  = a2_sonuc_q;
    a2_etiket_d = a2_etiket_q;
    case (a1_islem_q)
      ISLEM_CLZ: begin
        for (int unsigned j = 0; j < BAYT; j++) begin
          if (!dur) begin
            toplam = toplam + SONUC_BIT'(a1_lz_q[BAYT-1-j]);
            dur    = ~a1_sifir_q[BAYT-1-j];
          end
        end
      end
      ISLEM_CTZ: begin
        for (int unsigned j = 0; j < BAYT; j++) begin
          if (!dur) begin
            toplam = toplam + SONUC_BIT'(a1_tz_q[j]);
            dur    = ~a1_sifir_q[j];
          end
        end
      end
      ISLEM_CPOP: begin
        for (int unsigned j = 0; j < BAYT; j++) begin
          toplam = toplam + SONUC_BIT'(a1_pc_q[j]);
        end
      end
      default: toplam = '0;
    endcase
    if (temizle_i) begin
      a2_v_d = 1'b0;
    end else if (a2_load) begin
      a2_v_d = a1_v_q;
      if (a1_v_q) begin
        a2_sonuc_d  = toplam;
        a2_etiket_d = a1_etiket_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a1_v_q      <= 1'b0;
      a2_v_q      <= 1'b0;
      a2_sonuc_q  <= '0;
      a2_etiket_q <= '0;
    end else begin
      a1_v_q      <= a1_v_d;
      a2_v_q      <= a2_v_d;
      a2_sonuc_q  <= a2_sonuc_d;
      a2_etiket_q <= a2_etiket_d;
    end
  end

  // Payload registers are qualified by the valids and need no reset.
  always_ff @(posedge clk_i) begin
    a1_islem_q  <= a1_islem_d;
    a1_etiket_q <= a1_etiket_d;
    a1_lz_q     <= a1_lz_d;
    a1_tz_q     <= a1_tz_d;
    a1_pc_q     <= a1_pc_d;
    a1_sifir_q  <= a1_sifir_d;
  end
endmodule

// File: tb/tb_bit_sayici.sv
// tb_bit_sayici: randomized and directed checks of bit_sayici (32-bit and
// 64-bit instances) against a bit-level reference model and an in-order
// scoreboard tracking how long each op has been in flight.
module tb_bit_sayici;
  logic clk = 1'b0;
  logic rst;
  logic temizle;
  logic temizle64;

  always #5 clk = ~clk;

  bit_sayici_if #(.VERI_BIT(32), .ETIKET_BIT(4)) bus32 ();
  bit_sayici_if #(.VERI_BIT(64), .ETIKET_BIT(4)) bus64 ();

  bit_sayici #(.VERI_BIT(32), .ETIKET_BIT(4)) dut32 (
    .clk_i(clk), .rst_i(rst), .temizle_i(temizle), .bus(bus32)
  );
  bit_sayici #(.VERI_BIT(64), .ETIKET_BIT(4)) dut64 (
    .clk_i(clk), .rst_i(rst), .temizle_i(temizle64), .bus(bus64)
  );

  int n_vec = 0;
  int n_err = 0;

  int         q_res[$];
  logic [3:0] q_tag[$];
  int         q_age[$];
  logic       after_rst = 1'b0;

  task automatic check_val(input string tag, input longint obs, input longint want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, want);
    end
  endtask

  // Reference: plain bit-by-bit counting over the low w bits.
  function automatic int ref_res(input logic [63:0] v, input int w, input logic [1:0] op);
    int n;
    logic [63:0] m;
    n = 0;
    m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    case (op)
      2'b00: for (int i = w - 1; i >= 0 && !v[i]; i--) n++;
      2'b01: for (int i = 0; i < w && !v[i]; i++) n++;
      2'b10: n = $countones(v & m);
      default: n = 0;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] r;
    case ($urandom_range(0, 7))
      0: r = 32'h0;
      1: r = 32'hFFFF_FFFF;
      2: r = 32'd1 << $urandom_range(0, 31);
      default: r = $urandom;
    endcase
    return r;
  endfunction

  // One clock cycle on the 32-bit unit: drive at negedge, check the visible
  // state, then advance the scoreboard to what the next rising edge does.
  task automatic cyc(input logic g, input logic [1:0] op, input logic [31:0] d,
                     input logic [3:0] tg, input logic hi, input logic fl, input logic rs);
    logic exp_h, exp_v;
    @(negedge clk);
    bus32.gecerli_i = g;
    bus32.islem_i   = op;
    bus32.deger_i   = d;
    bus32.etiket_i  = tg;
    bus32.hazir_i   = hi;
    temizle         = fl;
    rst             = rs;
    #1;
    exp_h = !fl && !rs && (q_res.size() < 2 || hi);
    exp_v = (q_res.size() > 0) && (q_age[0] >= 1);
    check_val("hazir_o", bus32.hazir_o, exp_h);
    check_val("gecerli_o", bus32.gecerli_o, exp_v);
    if (exp_v && bus32.gecerli_o) begin
      check_val("sonuc_o", bus32.sonuc_o, q_res[0]);
      check_val("etiket_o", bus32.etiket_o, q_tag[0]);
    end
    if (after_rst) begin
      check_val("rst_sonuc_o", bus32.sonuc_o, 0);
      check_val("rst_etiket_o", bus32.etiket_o, 0);
    end
    after_rst = rs;
    if (exp_v && hi) begin
      void'(q_res.pop_front());
      void'(q_tag.pop_front());
      void'(q_age.pop_front());
    end
    foreach (q_age[i]) q_age[i]++;
    if (g && exp_h) begin
      q_res.push_back(ref_res({32'h0, d}, 32, op));
      q_tag.push_back(tg);
      q_age.push_back(0);
    end
    if (fl || rs) begin
      q_res.delete();
      q_tag.delete();
      q_age.delete();
    end
  endtask

  task automatic idle(input int n, input logic hi);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 32'h0, 4'h0, hi, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    temizle = 1'b0;
    temizle64 = 1'b0;
    bus32.gecerli_i = 1'b0; bus32.islem_i = 2'b00; bus32.deger_i = '0;
    bus32.etiket_i = '0;    bus32.hazir_i = 1'b1;
    bus64.gecerli_i = 1'b0; bus64.islem_i = 2'b00; bus64.deger_i = '0;
    bus64.etiket_i = '0;    bus64.hazir_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("reset gecerli_o", bus32.gecerli_o, 0);
    check_val("reset sonuc_o", bus32.sonuc_o, 0);
    check_val("reset etiket_o", bus32.etiket_o, 0);
    check_val("reset hazir_o", bus32.hazir_o, 1);
    check_val("reset64 gecerli_o", bus64.gecerli_o, 0);
    check_val("reset64 hazir_o", bus64.hazir_o, 1);

    // 64-bit instance, back-to-back with the consumer always ready.
    @(negedge clk);
    bus64.gecerli_i = 1'b1; bus64.islem_i = 2'b00; bus64.deger_i = 64'h1; bus64.etiket_i = 4'd5;
    @(negedge clk);
    bus64.islem_i = 2'b01; bus64.deger_i = 64'h1; bus64.etiket_i = 4'd6;
    @(negedge clk);
    bus64.islem_i = 2'b01; bus64.deger_i = 64'h8000_0000_0000_0000; bus64.etiket_i = 4'd7;
    #1;
    check_val("v64 gecerli_o 1", bus64.gecerli_o, 1);
    check_val("v64 clz 0x1", bus64.sonuc_o, 63);
    check_val("v64 etiket 1", bus64.etiket_o, 5);
    @(negedge clk);
    bus64.gecerli_i = 1'b0;
    #1;
    check_val("v64 ctz 0x1", bus64.sonuc_o, 0);
    check_val("v64 etiket 2", bus64.etiket_o, 6);
    @(negedge clk);
    #1;
    check_val("v64 ctz msb", bus64.sonuc_o, 63);
    check_val("v64 etiket 3", bus64.etiket_o, 7);
    @(negedge clk);
    #1;
    check_val("v64 gecerli_o idle", bus64.gecerli_o, 0);

    // Directed operands, back-to-back.
    cyc(1'b1, 2'b00, 32'h0001_0000, 4'd1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'b01, 32'h0001_0000, 4'd2, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 32'h0001_0000, 4'd3, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 32'h0000_0000, 4'd4, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'b01, 32'h0000_0000, 4'd5, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 32'h0000_0000, 4'd6, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 32'hFFFF_FFFF, 4'd7, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 32'hFFFF_FFFF, 4'd8, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 32'hF0F0_0001, 4'd9, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'b11, 32'hDEAD_BEEF, 4'd10, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Backpressure: tag 3 waits until hazir_i rises.
    cyc(1'b1, 2'b10, 32'h0000_000F, 4'd1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 32'h0000_00FF, 4'd2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 32'h0000_0FFF, 4'd3, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 32'h0000_0FFF, 4'd3, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 32'h0000_0FFF, 4'd3, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1);

    // Flush with two ops in flight and the consumer stalled.
    cyc(1'b1, 2'b00, 32'h0000_0100, 4'd11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'b01, 32'h0000_0100, 4'd12, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 32'h1, 4'd13, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);

    // Reset in the middle of a continuous stream.
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'(i % 3), pick(), 4'(i), 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 32'hFF, 4'd14, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'(i % 3), pick(), 4'(i + 4), 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Randomized traffic with bursts of backpressure, flushes and resets.
    for (int n = 0; n < 3000; n++) begin
      logic hi;
      hi = ((n / 100) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), pick(), 4'($urandom),
          hi, $urandom_range(0, 59) == 0, $urandom_range(0, 199) == 0);
    end

    // Drain with a bounded number of cycles.
    for (int i = 0; i < 10 && q_res.size() > 0; i++) idle(1, 1'b1);
    check_val("drain", q_res.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
